// File: rtl/y86_regfile_wb.sv
// Y86-64 program register file: written from the write-back stage, read
// combinationally by decode, with a sticky halt latch that freezes state.
module y86_regfile_wb #(
    parameter int         WIDTH = 64,
    parameter int         NREG  = 15,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       W_stat,
    input  logic [3:0]       W_dstE,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [WIDTH-1:0] d_rvalA,
    output logic [WIDTH-1:0] d_rvalB,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_val,
    output logic             halted,
    output logic [3:0]       halt_code,
    output logic [31:0]      wr_count
);

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    logic [WIDTH-1:0] regs [NREG];

    logic       wen;
    logic       writeE;
    logic       writeM;
    logic       haltNow;
    logic [1:0] writeCount;

    function automatic logic isException(input logic [3:0] stat);
        return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

    // A collision on one destination is one architectural write, not two.
    function automatic logic [1:0] countWrites(input logic       wE,
                                               input logic       wM,
                                               input logic [3:0] dstE,
                                               input logic [3:0] dstM);
        logic [1:0] n;
        n = {1'b0, wE} + {1'b0, wM};
        if (wE && wM && (dstE == dstM))
            n = 2'd1;
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] readPort(input logic [3:0] id);
        if ((id == RNONE) || (int'(id) >= NREG))
            return '0;
        return regs[id];
    endfunction

    always_comb begin
        wen        = (W_stat == STAT_AOK) && !halted;
        writeE     = wen && (W_dstE != RNONE);
        writeM     = wen && (W_dstM != RNONE);
        haltNow    = !halted && isException(W_stat);
        writeCount = countWrites(writeE, writeM, W_dstE, W_dstM);
    end

    // No internal bypass: reads always see the pre-edge contents.
    always_comb begin
        d_rvalA = readPort(d_srcA);
        d_rvalB = readPort(d_srcB);
        dbg_val = readPort(dbg_sel);
    end

    // Port M is checked first so it wins a same-destination collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (writeM && (W_dstM == 4'(i)))
                    regs[i] <= W_valM;
                else if (writeE && (W_dstE == 4'(i)))
                    regs[i] <= W_valE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted    <= 1'b0;
            halt_code <= 4'd0;
            wr_count  <= 32'd0;
        end else begin
            if (haltNow) begin
                halted    <= 1'b1;
                halt_code <= W_stat;
            end
            wr_count <= wr_count + 32'(writeCount);
        end
    end

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Scoreboard bench for y86_regfile_wb: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_y86_regfile_wb;

    localparam int WIDTH = 64;

    localparam int P_RVALA = 0;
    localparam int P_RVALB = 1;
    localparam int P_DBG   = 2;
    localparam int P_HALT  = 3;
    localparam int P_CODE  = 4;
    localparam int P_WRCNT = 5;

    logic             clk;
    logic             rst_n;
    logic [3:0]       W_stat;
    logic [3:0]       W_dstE;
    logic [WIDTH-1:0] W_valE;
    logic [3:0]       W_dstM;
    logic [WIDTH-1:0] W_valM;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [WIDTH-1:0] d_rvalA;
    logic [WIDTH-1:0] d_rvalB;
    logic [3:0]       dbg_sel;
    logic [WIDTH-1:0] dbg_val;
    logic             halted;
    logic [3:0]       halt_code;
    logic [31:0]      wr_count;

    typedef struct {
        string       name;
        int          port;
        logic [63:0] exp;
    } expect_t;

    expect_t sb[$];
    int      checks = 0;
    int      errors = 0;

    y86_regfile_wb #(.WIDTH(WIDTH), .NREG(15), .RNONE(4'hF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .W_stat   (W_stat),
        .W_dstE   (W_dstE),
        .W_valE   (W_valE),
        .W_dstM   (W_dstM),
        .W_valM   (W_valM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_rvalA  (d_rvalA),
        .d_rvalB  (d_rvalB),
        .dbg_sel  (dbg_sel),
        .dbg_val  (dbg_val),
        .halted   (halted),
        .halt_code(halt_code),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] actual(input int port);
        case (port)
            P_RVALA: return d_rvalA;
            P_RVALB: return d_rvalB;
            P_DBG:   return dbg_val;
            P_HALT:  return {63'd0, halted};
            P_CODE:  return {60'd0, halt_code};
            default: return {32'd0, wr_count};
        endcase
    endfunction

    // Monitor: compares every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            expect_t e;
            logic [63:0] act;
            e   = sb.pop_front();
            act = actual(e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic expectVal(input string name, input int port, input logic [63:0] v);
        expect_t e;
        e.name = name;
        e.port = port;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        W_stat = 4'd0;
        W_dstE = 4'hF;
        W_valE = '0;
        W_dstM = 4'hF;
        W_valM = '0;
    endtask

    task automatic drive(input logic [3:0] stat, input logic [3:0] dE, input logic [63:0] vE,
                         input logic [3:0] dM, input logic [63:0] vM);
        W_stat = stat;
        W_dstE = dE;
        W_valE = vE;
        W_dstM = dM;
        W_valM = vM;
    endtask

    initial begin
        rst_n   = 1'b0;
        d_srcA  = 4'd3;
        d_srcB  = 4'hF;
        dbg_sel = 4'hF;
        bubble();
        repeat (2) cyc();
        expectVal("init_halted", P_HALT, 64'd0);
        expectVal("init_code", P_CODE, 64'd0);
        expectVal("init_wrcount", P_WRCNT, 64'd0);
        expectVal("init_reg3", P_RVALA, 64'd0);
        cyc();
        rst_n = 1'b1;

        // Load reg3 = 0x55; pre-edge read still 0.
        drive(4'd1, 4'd3, 64'h55, 4'hF, 64'd0);
        expectVal("load_pre", P_RVALA, 64'd0);
        cyc();
        bubble();
        expectVal("load_reg3", P_RVALA, 64'h55);
        expectVal("load_wrcount", P_WRCNT, 64'd1);
        cyc();

        // Mid-cycle async reset, with a write pending on the next edge.
        rst_n = 1'b0;
        drive(4'd1, 4'd3, 64'h77, 4'hF, 64'd0);
        #1;
        expectVal("rst_reg3", P_RVALA, 64'd0);
        expectVal("rst_wrcount", P_WRCNT, 64'd0);
        expectVal("rst_halted", P_HALT, 64'd0);
        cyc();
        rst_n = 1'b1;
        bubble();
        expectVal("rst_discard", P_RVALA, 64'd0);
        expectVal("rst_discard_cnt", P_WRCNT, 64'd0);
        cyc();

        // Dual write.
        drive(4'd1, 4'd2, 64'h1111, 4'd5, 64'h2222);
        cyc();
        d_srcA = 4'd2;
        d_srcB = 4'd5;
        expectVal("dual_a", P_RVALA, 64'h1111);
        expectVal("dual_b", P_RVALB, 64'h2222);
        expectVal("dual_cnt", P_WRCNT, 64'd2);
        // Collision on reg4: M wins, one write counted.
        drive(4'd1, 4'd4, 64'hAA, 4'd4, 64'hBB);
        cyc();
        d_srcA = 4'd4;
        d_srcB = 4'hF;
        expectVal("coll_reg4", P_RVALA, 64'hBB);
        expectVal("coll_cnt", P_WRCNT, 64'd3);
        expectVal("rnone_read", P_RVALB, 64'd0);
        // RNONE destinations write nothing.
        drive(4'd1, 4'hF, 64'h33, 4'hF, 64'h34);
        cyc();
        dbg_sel = 4'hF;
        expectVal("rnone_cnt", P_WRCNT, 64'd3);
        expectVal("rnone_dbg", P_DBG, 64'd0);
        // Bubble with a real destination writes nothing.
        drive(4'd0, 4'd1, 64'h44, 4'hF, 64'd0);
        cyc();
        dbg_sel = 4'd1;
        expectVal("bubble_reg1", P_DBG, 64'd0);
        expectVal("bubble_cnt", P_WRCNT, 64'd3);
        // Unknown status 5 also behaves as a bubble.
        drive(4'd5, 4'd1, 64'h45, 4'hF, 64'd0);
        cyc();
        expectVal("stat5_reg1", P_DBG, 64'd0);
        expectVal("stat5_halt", P_HALT, 64'd0);

        // Same-edge read returns pre-edge value.
        drive(4'd1, 4'd6, 64'h10, 4'hF, 64'd0);
        cyc();
        d_srcA = 4'd6;
        drive(4'd1, 4'd6, 64'h20, 4'hF, 64'd0);
        expectVal("same_edge_pre", P_RVALA, 64'h10);
        expectVal("same_edge_cnt", P_WRCNT, 64'd4);
        cyc();
        bubble();
        expectVal("same_edge_post", P_RVALA, 64'h20);
        expectVal("post_cnt", P_WRCNT, 64'd5);

        // Exception ADR: halt latches, no write.
        d_srcB = 4'd7;
        drive(4'd3, 4'd7, 64'h99, 4'hF, 64'd0);
        expectVal("pre_halt", P_HALT, 64'd0);
        cyc();
        expectVal("halt_set", P_HALT, 64'd1);
        expectVal("halt_code", P_CODE, 64'd3);
        expectVal("halt_nowrite", P_RVALB, 64'd0);
        expectVal("halt_cnt", P_WRCNT, 64'd5);
        drive(4'd1, 4'd7, 64'h99, 4'd8, 64'h5);
        cyc();
        dbg_sel = 4'd8;
        expectVal("halted_reg7", P_RVALB, 64'd0);
        expectVal("halted_reg8", P_DBG, 64'd0);
        expectVal("halted_cnt", P_WRCNT, 64'd5);
        drive(4'd2, 4'hF, 64'd0, 4'hF, 64'd0);
        cyc();
        bubble();
        expectVal("sticky_code", P_CODE, 64'd3);
        expectVal("sticky_halt", P_HALT, 64'd1);
        cyc();

        // Reset clears halt, writes resume afterwards.
        rst_n = 1'b0;
        #1;
        expectVal("rst2_halt", P_HALT, 64'd0);
        expectVal("rst2_code", P_CODE, 64'd0);
        expectVal("rst2_reg6", P_RVALA, 64'd0);
        cyc();
        rst_n = 1'b1;
        dbg_sel = 4'd0;
        drive(4'd1, 4'd0, 64'hDEAD, 4'hE, 64'hBEEF);
        cyc();
        bubble();
        d_srcB = 4'hE;
        expectVal("resume_reg0", P_DBG, 64'hDEAD);
        expectVal("resume_regE", P_RVALB, 64'hBEEF);
        expectVal("resume_cnt", P_WRCNT, 64'd2);

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 10) begin
                cyc();
                budget++;
            end
            if (sb.size() > 0) begin
                errors++;
                checks++;
                $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
